// File: rtl/twoway_valid_ready_trace_tap.sv
// Zero-latency valid/ready pass-through that logs every completed handshake
// as {timestamp, payload} into a small circular FIFO with selectable full policy.
module twoway_valid_ready_trace_tap #(
  parameter int DATA_WIDTH   = 64,
  parameter int TS_WIDTH     = 32,
  parameter int LOG_DEPTH    = 8,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               log_en,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               log_valid,
  input  logic                               log_ready,
  output logic [TS_WIDTH+DATA_WIDTH-1:0]     log_data,
  output logic [$clog2(LOG_DEPTH):0]         log_count,
  output logic [15:0]                        drop_count
);

  localparam int AW = $clog2(LOG_DEPTH);
  localparam int CW = AW + 1;

  logic [TS_WIDTH-1:0]            ts;
  logic [TS_WIDTH+DATA_WIDTH-1:0] mem [LOG_DEPTH];
  logic [AW-1:0]                  wr_ptr;
  logic [AW-1:0]                  rd_ptr;
  logic [CW-1:0]                  count;
  logic                           full;
  logic                           block;
  logic                           fire;
  logic                           push;
  logic                           pop;
  logic                           drop;

  // Valid/ready contract on all three channels: a transfer happens in a cycle
  // exactly when valid && ready; valid never waits on ready. full is taken from
  // the registered count only, so log_ready never reaches in_ready/out_valid.
  assign full  = !rst && (count == CW'(LOG_DEPTH));
  assign block = log_en && full && !DROP_ON_FULL;

  assign out_valid = in_valid && !block;
  assign in_ready  = out_ready && !block;
  assign out_data  = in_data;
  assign fire      = in_valid && in_ready;

  assign push = fire && log_en && !full;
  assign drop = fire && log_en && full;
  assign pop  = log_valid && log_ready;

  assign log_valid = (count != '0);
  assign log_data  = mem[rd_ptr];
  assign log_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= {ts, in_data};
  end

endmodule

// File: tb/tb_twoway_valid_ready_trace_tap.sv
// Bench for twoway_valid_ready_trace_tap: back-pressure instance (a_*) and a
// drop-mode instance with a 4-bit timestamp (b_*), each against a queue model.
module tb_twoway_valid_ready_trace_tap;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A: back-pressure on full ----------------
  logic        a_rst, a_log_en, a_in_valid, a_out_ready, a_log_ready;
  logic [63:0] a_in_data, a_out_data;
  logic        a_in_ready, a_out_valid, a_log_valid;
  logic [95:0] a_log_data;
  logic [3:0]  a_log_count;
  logic [15:0] a_drop_count;

  twoway_valid_ready_trace_tap #(
    .DATA_WIDTH(64), .TS_WIDTH(32), .LOG_DEPTH(8), .DROP_ON_FULL(1'b0)
  ) dut_a (
    .clk(clk), .rst(a_rst), .log_en(a_log_en),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .log_valid(a_log_valid), .log_ready(a_log_ready), .log_data(a_log_data),
    .log_count(a_log_count), .drop_count(a_drop_count)
  );

  // ---------------- instance B: drop on full, 4-bit timestamp ----------------
  logic        b_rst, b_log_en, b_in_valid, b_out_ready, b_log_ready;
  logic [63:0] b_in_data, b_out_data;
  logic        b_in_ready, b_out_valid, b_log_valid;
  logic [67:0] b_log_data;
  logic [3:0]  b_log_count;
  logic [15:0] b_drop_count;

  twoway_valid_ready_trace_tap #(
    .DATA_WIDTH(64), .TS_WIDTH(4), .LOG_DEPTH(8), .DROP_ON_FULL(1'b1)
  ) dut_b (
    .clk(clk), .rst(b_rst), .log_en(b_log_en),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .log_valid(b_log_valid), .log_ready(b_log_ready), .log_data(b_log_data),
    .log_count(b_log_count), .drop_count(b_drop_count)
  );

  // ---------------- scoreboard ----------------
  logic [95:0] exp_q[$];    // instance A entries {ts32, data64}
  logic [95:0] exp_q_b[$];  // instance B entries {28'b0, ts4, data64}
  logic [31:0] ts_m   [2];
  logic [15:0] drop_m [2];
  logic        fire_m [2];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int id, input logic r, input logic le, input logic iv,
                            input logic ordy, input logic lrdy, input logic [63:0] d,
                            input logic o_irdy, input logic o_ov, input logic [63:0] o_od,
                            input logic o_lv, input logic [95:0] o_ld,
                            input logic [3:0] o_lc, input logic [15:0] o_dc);
    int          sz;
    logic        full, blk, fire, push, pop, drop, drop_mode;
    logic [95:0] entry;
    drop_mode = (id == 1);
    sz   = (id == 0) ? exp_q.size() : exp_q_b.size();
    full = !r && (sz == 8);
    blk  = le && full && !drop_mode;
    chk(id == 0 ? "a_in_ready"  : "b_in_ready",  96'(o_irdy), 96'(ordy && !blk));
    chk(id == 0 ? "a_out_valid" : "b_out_valid", 96'(o_ov),   96'(iv && !blk));
    chk(id == 0 ? "a_out_data"  : "b_out_data",  96'(o_od),   96'(d));
    if (!r) begin
      chk(id == 0 ? "a_log_valid"  : "b_log_valid",  96'(o_lv), 96'(sz != 0));
      chk(id == 0 ? "a_log_count"  : "b_log_count",  96'(o_lc), 96'(sz));
      chk(id == 0 ? "a_drop_count" : "b_drop_count", 96'(o_dc), 96'(drop_m[id]));
      if (sz != 0)
        chk(id == 0 ? "a_log_data" : "b_log_data", o_ld, (id == 0) ? exp_q[0] : exp_q_b[0]);
    end
    fire = iv && ordy && !blk;
    fire_m[id] = fire && !r;
    pop  = (sz != 0) && lrdy;
    push = fire && le && !full;
    drop = fire && le && full;
    if (r) begin
      if (id == 0) exp_q.delete(); else exp_q_b.delete();
      ts_m[id]   = '0;
      drop_m[id] = '0;
    end else begin
      if (id == 0) entry = {ts_m[0], d};
      else         entry = {28'd0, ts_m[1][3:0], d};
      if (pop)  begin if (id == 0) void'(exp_q.pop_front()); else void'(exp_q_b.pop_front()); end
      if (push) begin if (id == 0) exp_q.push_back(entry);   else exp_q_b.push_back(entry);   end
      if (drop && drop_m[id] != 16'hFFFF) drop_m[id] = drop_m[id] + 16'd1;
      ts_m[id] = (id == 0) ? ts_m[0] + 32'd1 : ((ts_m[1] + 32'd1) & 32'hF);
    end
  endtask

  always @(negedge clk) begin
    model_step(0, a_rst, a_log_en, a_in_valid, a_out_ready, a_log_ready, a_in_data,
               a_in_ready, a_out_valid, a_out_data, a_log_valid, a_log_data,
               a_log_count, a_drop_count);
    model_step(1, b_rst, b_log_en, b_in_valid, b_out_ready, b_log_ready, b_in_data,
               b_in_ready, b_out_valid, b_out_data, b_log_valid, 96'(b_log_data),
               b_log_count, b_drop_count);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  // Holds a_in_valid until `target` fires have happened on A; data = fire index + 1.
  task automatic fire_a_until(inout int nfired, input int target);
    int guard;
    guard = 0;
    a_in_valid = 1'b1;
    a_in_data  = 64'(nfired + 1);
    while (nfired < target && guard < 60) begin
      cyc();
      guard++;
      if (fire_m[0]) begin
        nfired++;
        a_in_data = 64'(nfired + 1);
      end
    end
    chk("a_fire_budget", 96'(nfired), 96'(target));
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic        le;
    logic        iv;
    logic        ordy;
    logic [63:0] d;
    logic        exp_ir;
    logic        exp_ov;
  } vec_t;

  vec_t vt[8];

  // ---------------- main sequence ----------------
  initial begin
    int nf;
    int guard;

    vt[0] = '{1'b1, 1'b1, 1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b1};
    vt[1] = '{1'b1, 1'b1, 1'b0, 64'h0,                   1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0001, 1'b1, 1'b1};
    vt[4] = '{1'b1, 1'b0, 1'b0, 64'h5A5A,                1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 64'h1,                   1'b1, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b1, {$urandom, $urandom},    1'b1, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b0, {$urandom, $urandom},    1'b0, 1'b1};

    a_rst = 1'b1; a_log_en = 1'b1; a_in_valid = 1'b0; a_in_data = '0;
    a_out_ready = 1'b1; a_log_ready = 1'b1;
    b_rst = 1'b1; b_log_en = 1'b1; b_in_valid = 1'b0; b_in_data = '0;
    b_out_ready = 1'b1; b_log_ready = 1'b1;
    repeat (3) cyc();
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Reset state
    mid();
    chk("rst_log_valid",  96'(a_log_valid),  96'(0));
    chk("rst_log_count",  96'(a_log_count),  96'(0));
    chk("rst_drop_count", 96'(a_drop_count), 96'(0));
    cyc();

    // Basic capture at timestamp 5
    guard = 0;
    while (ts_m[0] != 32'd5 && guard < 20) begin cyc(); guard++; end
    chk("basic_ts_wait", 96'(ts_m[0]), 96'(5));
    a_in_valid = 1'b1; a_in_data = 64'hA5;
    mid();
    chk("basic_out_data",  96'(a_out_data),  96'(64'hA5));
    chk("basic_out_valid", 96'(a_out_valid), 96'(1));
    cyc();
    a_in_valid = 1'b0;
    mid();
    chk("basic_log_valid", 96'(a_log_valid), 96'(1));
    chk("basic_log_data",  a_log_data,       {32'd5, 64'hA5});
    cyc();
    mid();
    chk("basic_log_count", 96'(a_log_count), 96'(0));
    cyc();

    // Table of data-path vectors with an empty, draining FIFO
    for (int i = 0; i < 8; i++) begin
      a_log_en = vt[i].le; a_in_valid = vt[i].iv; a_out_ready = vt[i].ordy; a_in_data = vt[i].d;
      mid();
      chk($sformatf("vec%0d_in_ready", i),  96'(a_in_ready),  96'(vt[i].exp_ir));
      chk($sformatf("vec%0d_out_valid", i), 96'(a_out_valid), 96'(vt[i].exp_ov));
      chk($sformatf("vec%0d_out_data", i),  96'(a_out_data),  96'(vt[i].d));
      cyc();
    end
    a_log_en = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (3) cyc();

    // Back-pressure fill: 8 beats land, then the path blocks
    a_log_ready = 1'b0;
    nf = 0;
    fire_a_until(nf, 8);
    mid();
    chk("bp_in_ready_full",  96'(a_in_ready),  96'(0));
    chk("bp_out_valid_full", 96'(a_out_valid), 96'(0));
    chk("bp_log_count_full", 96'(a_log_count), 96'(8));
    cyc();
    mid();
    chk("bp_still_blocked", 96'(a_in_ready), 96'(0));
    cyc();
    a_log_ready = 1'b1;
    mid();
    chk("bp_pop_head",        96'(a_log_data[63:0]), 96'(1));
    chk("bp_pop_no_unblock",  96'(a_in_ready),       96'(0));
    cyc();
    a_log_ready = 1'b0;
    mid();
    chk("bp_unblock_next", 96'(a_in_ready),  96'(1));
    chk("bp_count_after",  96'(a_log_count), 96'(7));
    cyc();
    a_log_ready = 1'b1;
    fire_a_until(nf, 10);
    a_in_valid = 1'b0;
    repeat (12) cyc();

    // Steady state push/pop at occupancy 3
    a_log_ready = 1'b0;
    nf = 0;
    fire_a_until(nf, 3);
    a_log_ready = 1'b1;
    a_in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a_in_data = {$urandom, $urandom};
      mid();
      chk("steady_log_count", 96'(a_log_count), 96'(3));
      cyc();
    end
    a_in_valid = 1'b0;
    repeat (6) cyc();

    // log_en low: data flows, nothing captured
    a_log_en = 1'b0;
    a_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_in_data = 64'(100 + k);
      mid();
      chk("noen_out_valid", 96'(a_out_valid), 96'(1));
      cyc();
    end
    a_in_valid = 1'b0;
    mid();
    chk("noen_log_count", 96'(a_log_count), 96'(0));
    cyc();
    a_log_en = 1'b1;

    // Mid-operation reset with 5 queued entries
    a_log_ready = 1'b0;
    nf = 0;
    fire_a_until(nf, 5);
    a_in_valid = 1'b0;
    a_rst = 1'b1;
    cyc();
    a_rst = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'h77;
    mid();
    chk("mrst_log_valid",  96'(a_log_valid),  96'(0));
    chk("mrst_log_count",  96'(a_log_count),  96'(0));
    chk("mrst_drop_count", 96'(a_drop_count), 96'(0));
    cyc();
    a_in_valid = 1'b0;
    mid();
    chk("mrst_first_entry", a_log_data, {32'd0, 64'h77});
    cyc();
    a_log_ready = 1'b1;
    repeat (3) cyc();

    // Drop mode on B: 12 beats into 8 slots
    b_log_ready = 1'b0;
    b_in_valid  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      b_in_data = 64'(i);
      mid();
      chk("drop_out_valid", 96'(b_out_valid), 96'(1));
      chk("drop_in_ready",  96'(b_in_ready),  96'(1));
      cyc();
    end
    b_in_valid = 1'b0;
    mid();
    chk("drop_log_count",  96'(b_log_count),  96'(8));
    chk("drop_drop_count", 96'(b_drop_count), 96'(4));
    cyc();

    // log_en low while full: no further drops
    b_log_en = 1'b0;
    b_in_valid = 1'b1;
    repeat (5) cyc();
    b_in_valid = 1'b0;
    mid();
    chk("noen_full_drop", 96'(b_drop_count), 96'(4));
    chk("noen_full_cnt",  96'(b_log_count),  96'(8));
    cyc();
    b_log_en = 1'b1;

    // Drain B: payloads 1..8 in order
    b_log_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      mid();
      chk("drop_order", 96'(b_log_data[63:0]), 96'(i));
      cyc();
    end

    // Timestamp wrap on the 4-bit counter: 15 then 0
    guard = 0;
    while (ts_m[1] != 32'd15 && guard < 40) begin cyc(); guard++; end
    chk("wrap_ts_wait", 96'(ts_m[1]), 96'(15));
    b_in_valid = 1'b1; b_in_data = 64'hF0;
    cyc();
    b_in_data = 64'hF1;
    mid();
    chk("wrap_entry_15", 96'(b_log_data), 96'({4'hF, 64'hF0}));
    cyc();
    b_in_valid = 1'b0;
    mid();
    chk("wrap_entry_0", 96'(b_log_data), 96'({4'h0, 64'hF1}));
    cyc();
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/twoway_valid_ready_trace_tap.md
# twoway_valid_ready_trace_tap

Parametrised pass-through tap for one valid/ready channel. It forwards the input stream to the output with zero latency. Every completed handshake is captured, together with a free-running cycle timestamp, into an internal log FIFO. The FIFO decouples log back-pressure from the data path. The block sits between an AXI channel endpoint and the trace recorder, in place of a plain fork-based logger.

## Interface

Parameters:
- DATA_WIDTH, 64: payload width of the traced channel.
- TS_WIDTH, 32: timestamp counter width; ≥1.
- LOG_DEPTH, 8: log FIFO depth; power of two, ≥2.
- DROP_ON_FULL, 0: full-FIFO policy. 0 = back-pressure the data path; 1 = keep forwarding and drop log entries.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- log_en  in  1  capture enable, sampled each cycle; 0 = no pushes, but the data path still flows.
- in_valid  in  1  upstream valid.
- in_ready  out  1  upstream ready.
- in_data  in  DATA_WIDTH  upstream payload.
- out_valid  out  1  downstream valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_WIDTH  downstream payload; equals in_data.
- log_valid  out  1  log entry available.
- log_ready  in  1  log consumer ready.
- log_data  out  TS_WIDTH+DATA_WIDTH  log entry: {timestamp, payload}, with the timestamp in the MSBs.
- log_count  out  $clog2(LOG_DEPTH)+1  current FIFO occupancy.
- drop_count  out  16  number of dropped entries; saturates at 0xFFFF.

## Operation

Signal definitions:
- block = log_en && full && !DROP_ON_FULL.
- out_valid = in_valid && !block.
- in_ready = out_ready && !block.
- Handshake fire = in_valid && in_ready.

Capture:
- Timestamp counter: reset to 0, increments every cycle, wraps modulo 2^TS_WIDTH.
- The timestamp logged is the counter value in the fire cycle.
- push = fire && log_en && !full.
- drop = fire && log_en && full. This is only reachable when DROP_ON_FULL=1.
- Each drop increments drop_count, saturating at 0xFFFF.

Log FIFO:
- Register-array circular buffer with wr_ptr, rd_ptr and count.
- pop = log_valid && log_ready.
- log_valid = (count != 0).
- log_data = mem[rd_ptr], driven combinationally from the registered array.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap at LOG_DEPTH.
- full = (count == LOG_DEPTH), based on the registered count only.
- A pop in the same cycle does not free a slot for a push or unblock in_ready. This keeps log_ready off the combinational path to in_ready.

No combinational path exists from log_ready to in_ready, out_valid or log_valid.

## Timing

Reset values:
- log_valid = 0, log_count = 0, drop_count = 0.
- Timestamp = 0, pointers = 0.
- in_ready and out_valid are combinational: during reset they follow the rules above with full = 0.

Latency:
- Data path: 0 cycles.
- A capture fired in cycle T is visible on log_valid/log_data in cycle T+1.
- log_count reflects pushes and pops at the cycle after they occur.

Ordering:
- Log order equals handshake order.
- An entry is held stable until popped.

Boundary behaviour:
- Back-to-back fires: one entry per cycle.
- Full with DROP_ON_FULL=0: in_ready = 0 and out_valid = 0 until a pop has decremented count, i.e. the cycle after the pop.
- Full with DROP_ON_FULL=1: the data path keeps flowing and drop_count counts each lost fire.
- log_en deasserted: nothing is pushed and nothing is dropped; the FIFO drains normally and block = 0.
- Reset mid-operation: the FIFO is emptied, queued entries are discarded, and the timestamp restarts at 0 on the next cycle.

## Test plan

- **Basic capture.** DATA_WIDTH=64, TS_WIDTH=32, LOG_DEPTH=8. Deassert rst after cycle 2. Send in_data=0xA5 with out_ready=1 and log_ready=1 at timestamp 5. Required: out_data=0xA5 in the same cycle; log_valid=1 one cycle later with log_data={32'd5, 64'hA5}; log_count returns to 0.
- **Back-pressure fill.** DROP_ON_FULL=0, log_ready=0. Send 10 consecutive beats with values 1..10. Required: beats 1..8 pass; in_ready=0 after the 8th fire with log_count=8. Raise log_ready for one cycle: the entry with value 1 pops, and in_ready rises the following cycle.
- **Drop mode.** DROP_ON_FULL=1, log_ready=0. Send 12 beats. Required: all 12 forwarded; log_count=8; drop_count=4; the 8 logged payloads are 1..8 in order.
- **Simultaneous push/pop at steady state.** log_count=3, continuous fires and pops for 20 cycles. Required: log_count stays 3; timestamps in the log are strictly increasing by 1.
- **Enable and wrap.** log_en=0 during 5 fires: no entries, drop_count unchanged, data forwarded. With TS_WIDTH=4, a fire at counter value 15 followed by a fire on the next cycle logs timestamps 15 then 0.
- **Mid-operation reset.** Assert rst with log_count=5. Required: log_valid=0 and log_count=0 in the next cycle; drop_count=0; the first post-reset fire logs timestamp 0 or its correct post-reset value.
